barrett_reduction_scheduler: RTL and testbench

- Shares one sequential modular-reduction datapath (modified Barrett, x mod Q) between NUM_REQ requesters.
- Round-robin arbitration over requesters. A multi-cycle FSM sequences the reduction: multiply-by-mu, shift, multiply-by-Q, subtract, correct.
- Returns a fully reduced residue tagged with the requester ID over a single valid/ready response port.
- Sits between NTT/polynomial-multiply lanes and the shared reducer in the HE datapath.

---
 rtl/barrett_reduction_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_barrett_reduction_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduction_scheduler.sv
// Round-robin arbiter in front of one shared multi-cycle Barrett reducer (x mod Q).
// Optional macro BARRETT_RANGE_CHECK_EN adds resp_err for operands at or above Q*Q.
module barrett_reduction_scheduler #(
  parameter int unsigned     Q       = 32'd65537,
  parameter int unsigned     K       = $clog2(Q),
  parameter longint unsigned MU      = (64'd1 << (32'd2 * K)) / Q,
  parameter int unsigned     NUM_REQ = 32'd4,
  parameter int unsigned     ID_W    = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*2*K-1:0] req_x,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [K-1:0]           resp_y,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
`ifdef BARRETT_RANGE_CHECK_EN
  ,
  output logic                   resp_err
`endif
);

  localparam int unsigned X_W  = 32'd2 * K;
  localparam int unsigned MU_W = $clog2(MU + 64'd1);
  localparam int unsigned M_W  = X_W + MU_W;
  localparam int unsigned P_W  = MU_W + K;
  localparam int unsigned D_W  = (P_W > X_W) ? P_W : X_W;
  localparam int unsigned R_W  = K + 32'd2;

  localparam logic [MU_W-1:0] MU_C = MU_W'(MU);
  localparam logic [K-1:0]    Q_C  = K'(Q);
  localparam logic [R_W-1:0]  Q1_C = R_W'(Q);
  localparam logic [R_W-1:0]  Q2_C = R_W'(64'(Q) * 64'd2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    MUL2 = 3'd2,
    SUB  = 3'd3,
    CORR = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [ID_W-1:0]     ptr_r;
  logic [X_W-1:0]      x_r;
  logic [ID_W-1:0]     id_r;
  logic [M_W-1:0]      m_r;
  logic [P_W-1:0]      p_r;
  logic [R_W-1:0]      r_r;
  logic [K-1:0]        resp_y_r;
  logic [ID_W-1:0]     resp_id_r;
  logic                resp_valid_r;
  logic                busy_r;
  logic [ID_W:0]       pick_s;
  logic                grant_found_s;
  logic [ID_W-1:0]     grant_s;
  logic [X_W-1:0]      x_sel_s;
  logic [MU_W-1:0]     t_s;

  // First valid requester after ptr, with wrap-around; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    idx  = ptr;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx  = (idx == ID_W'(NUM_REQ - 32'd1)) ? '0 : idx + ID_W'(32'd1);
      pick = (!pick[ID_W] && valid[idx]) ? {1'b1, idx} : pick;
    end
    return pick;
  endfunction

  // r is known to lie in [0, 3Q), so at most one subtraction of Q or 2Q is needed.
  function automatic logic [K-1:0] corr_fn(input logic [R_W-1:0] r);
    logic [R_W-1:0] v;
    if (r >= Q2_C) begin
      v = r - Q2_C;
    end else if (r >= Q1_C) begin
      v = r - Q1_C;
    end else begin
      v = r;
    end
    return K'(v);
  endfunction

  assign pick_s        = rr_pick(req_valid, ptr_r);
  assign grant_found_s = pick_s[ID_W] & ~reset & (state_r == IDLE);
  assign grant_s       = pick_s[ID_W-1:0];
  assign t_s           = MU_W'(m_r >> X_W);

  // Operand mux for the granted requester.
  always_comb begin
    x_sel_s = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      x_sel_s = x_sel_s | (req_x[i*X_W +: X_W] & {X_W{grant_s == ID_W'(i)}});
    end
  end

  // One-hot accept, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (grant_found_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state sequencing of the reduction.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_nx_s = MUL1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL1: state_nx_s = MUL2;
      MUL2: state_nx_s = SUB;
      SUB:  state_nx_s = CORR;
      CORR: state_nx_s = DONE;
      DONE: begin
        if (resp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      busy_r       <= (state_nx_s != IDLE);
      resp_valid_r <= (state_nx_s == DONE);
    end
  end

  // Arbitration pointer and reduction datapath, one step per state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r     <= ID_W'(NUM_REQ - 32'd1);
      x_r       <= '0;
      id_r      <= '0;
      m_r       <= '0;
      p_r       <= '0;
      r_r       <= '0;
      resp_y_r  <= '0;
      resp_id_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            x_r   <= x_sel_s;
            id_r  <= grant_s;
            ptr_r <= grant_s;
          end
        end
        MUL1: m_r <= M_W'(x_r) * M_W'(MU_C);
        MUL2: p_r <= P_W'(t_s) * P_W'(Q_C);
        // The quotient estimate never exceeds x/Q, so the difference is non-negative.
        SUB:  r_r <= R_W'(D_W'(x_r) - D_W'(p_r));
        CORR: begin
          resp_y_r  <= corr_fn(r_r);
          resp_id_r <= id_r;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BARRETT_RANGE_CHECK_EN
  localparam int unsigned   XE_W = X_W + 32'd1;
  localparam logic [X_W:0]  QQ_C = XE_W'(64'(Q) * 64'(Q));

  logic resp_err_r;

  // Domain flag, registered alongside the residue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_err_r <= 1'b0;
    end else if (state_r == CORR) begin
      resp_err_r <= ({1'b0, x_r} >= QQ_C);
    end
  end

  assign resp_err = resp_err_r;
`endif

  assign resp_valid = resp_valid_r;
  assign resp_y     = resp_y_r;
  assign resp_id    = resp_id_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_barrett_reduction_scheduler.sv
// Scoreboard bench for barrett_reduction_scheduler: arithmetic x mod Q reference,
// round-robin grant model, latency/backpressure/reset checks.
module tb_barrett_reduction_scheduler;

  localparam int unsigned Q       = 32'd65537;
  localparam int unsigned K       = $clog2(Q);
  localparam int unsigned NUM_REQ = 32'd4;
  localparam int unsigned ID_W    = 32'd2;
  localparam int unsigned X_W     = 32'd2 * K;
  localparam int          LAT     = 5;  // accept edge plus four more edges

  logic                   clock;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*X_W-1:0] req_x;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [K-1:0]           resp_y;
  logic [ID_W-1:0]        resp_id;
  logic                   busy;
`ifdef BARRETT_RANGE_CHECK_EN
  logic                   resp_err;
`endif

  barrett_reduction_scheduler #(.Q(Q), .NUM_REQ(NUM_REQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_id    (resp_id),
    .busy       (busy)
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  typedef struct {
    int              id;
    longint unsigned y;
    bit              err;
    int              due;
  } exp_t;

  exp_t           sb_q[$];
  logic [X_W-1:0] pend[NUM_REQ][$];
  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  bit             m_idle = 1'b1;
  int             m_ptr = NUM_REQ - 1;
  int             m_hs_from = 0;
  bit             cur_seen = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin: first valid requester after the last one served.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int o = 1; o <= NUM_REQ; o++) begin
      if (v[(ptr + o) % NUM_REQ]) return (ptr + o) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic bit exp_err(input logic [X_W-1:0] x);
`ifdef BARRETT_RANGE_CHECK_EN
    return 64'(x) >= 64'(Q) * 64'(Q);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [X_W-1:0] rand_x();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(32'd0, 32'd3))
      32'd0:   return w[X_W-1:0];
      32'd1:   return X_W'(w[16:0]);
      32'd2:   return X_W'(64'h3_FFFF_FFFF - 64'(w[7:0]));
      default: return X_W'(64'(Q) * 64'(w[16:0]) + 64'(w[20:18]));
    endcase
  endfunction

  function automatic bit pending_work();
    bit any;
    any = (req_valid != '0) || (sb_q.size() != 0) || !m_idle;
    for (int i = 0; i < NUM_REQ; i++) any = any || (pend[i].size() != 0);
    return any;
  endfunction

  // Grant / busy model and scoreboard producer.
  always @(negedge clock) begin
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [X_W-1:0] xg;
    if (reset) begin
      chk("reset_outputs", {req_ready, resp_valid, resp_y, resp_id, busy}, 0);
      m_idle = 1'b1;
      m_ptr  = NUM_REQ - 1;
      sb_q.delete();
    end else begin
      g = m_idle ? model_pick(req_valid, m_ptr) : -1;
      exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(!m_idle));
      if (g >= 0) begin
        xg = req_x[g*X_W +: X_W];
        sb_q.push_back('{g, 64'(xg) % 64'(Q), exp_err(xg), cyc + LAT});
        m_ptr     = g;
        m_idle    = 1'b0;
        m_hs_from = cyc + LAT;
      end else if (!m_idle && cyc >= m_hs_from && resp_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clock) begin
    if (reset) begin
      cur_seen = 1'b0;
    end else begin
      if (sb_q.size() > 0 && !cur_seen && cyc == sb_q[0].due)
        chk("resp_valid_on_time", 64'(resp_valid), 1);
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("resp_valid_spurious", 64'(resp_valid), 0);
        end else begin
          if (!cur_seen) begin
            chk("resp_latency", 64'(cyc), 64'(sb_q[0].due));
            cur_seen = 1'b1;
          end
          chk("resp_id", 64'(resp_id), 64'(sb_q[0].id));
          chk("resp_y", 64'(resp_y), sb_q[0].y);
`ifdef BARRETT_RANGE_CHECK_EN
          chk("resp_err", 64'(resp_err), 64'(sb_q[0].err));
`endif
          if (resp_ready) begin
            void'(sb_q.pop_front());
            cur_seen = 1'b0;
          end
        end
      end
    end
  end

  // One clock of requester behaviour: reload or drop after an accept.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge clock);
    acc = req_ready & req_valid;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] || !req_valid[i]) begin
        if (pend[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_x[i*X_W +: X_W] = pend[i].pop_front();
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending_work() && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 64'(pending_work()), 0);
  endtask

  initial begin
    logic [X_W-1:0] dir_x[$];
    logic [X_W-1:0] bnd_x[$];
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    resp_ready = 1'b1;

    // Requester 0 alone, back to back.
    dir_x = '{34'd21, 34'd10, 34'd66287, 34'd596583, 34'd262240};
    foreach (dir_x[j]) pend[0].push_back(dir_x[j]);
    drain(200);

    // Boundary operands spread over requesters.
    bnd_x = '{34'h3_FFFF_FFFF, 34'd65537, 34'd65536, 34'd0,
              34'd4295098369, 34'd4295098368, 34'd131074};
    foreach (bnd_x[j]) pend[j % NUM_REQ].push_back(bnd_x[j]);
    drain(300);

    // All requesters contending with distinct operands.
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i].push_back(X_W'(64'd1000003 * 64'(i + 1) + 64'd7));
      pend[i].push_back(X_W'(64'd77777777 * 64'(i + 3)));
    end
    drain(300);

    // Random traffic with random consumer backpressure.
    repeat (600) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (pend[i].size() == 0 && $urandom_range(32'd0, 32'd3) == 32'd0)
          pend[i].push_back(rand_x());
      resp_ready = ($urandom_range(32'd0, 32'd3) != 32'd0);
      step();
    end
    resp_ready = 1'b1;
    drain(1000);

    // Long hold in DONE.
    resp_ready = 1'b0;
    pend[2].push_back(34'd596583);
    repeat (18) step();
    resp_ready = 1'b1;
    drain(100);

    // Reset while the reducer is in its second multiply step.
    pend[1].push_back(34'd262240);
    step();
    @(negedge clock);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_x[i*X_W +: X_W] = X_W'(64'd123457 * 64'(i + 2));
    #1;
    chk("async_rst_req_ready", 64'(req_ready), 0);
    chk("async_rst_resp_valid", 64'(resp_valid), 0);
    chk("async_rst_resp_y", 64'(resp_y), 0);
    chk("async_rst_resp_id", 64'(resp_id), 0);
    chk("async_rst_busy", 64'(busy), 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    drain(200);

    repeat (4) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
